keypad_scanner: RTL and testbench

Column-scan driver and debouncer for the 4x4 matrix keypad: the driving end of the column/row interface that the keypad decoder reads. It rotates a single active-low column across the matrix and samples the active-low rows. When a key is pressed it freezes the column on that key and debounces both the press and the release. It emits one key event per physical press, using the same key-code map as the decoder, to the vending-machine control logic.

---
 rtl/keypad_scanner_pkg.sv | 41 ++++
 rtl/keypad_scanner_if.sv | 26 ++
 rtl/keypad_sync.sv | 31 +++
 rtl/keypad_scanner.sv | 148 ++++++++++++++
 tb/tb_keypad_scanner.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad column scanner: FSM state encoding,
// idle/reset patterns for the row and column buses, and small helpers for
// classifying and encoding active-low row patterns.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_e;

  localparam logic [3:0] ROW_IDLE  = 4'b1111;
  localparam logic [3:0] COL_RESET = 4'b1110;

  // True when exactly one row line is pulled low (one key in the column).
  function automatic logic single_low(input logic [3:0] rows);
    logic [2:0] n_low;
    n_low = '0;
    for (int i = 0; i < 4; i++) begin
      n_low = n_low + {2'b00, ~rows[i]};
    end
    return (n_low == 3'd1);
  endfunction

  // Position of the low bit of a single-key row pattern.
  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Active-low one-cold column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Column/row bus between the keypad scanner and its neighbours. The scanner
// is the master: it drives the columns and the key event outputs and reads
// the rows. The slave view is the matrix/consumer side.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] shift_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output shift_col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  shift_col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_sync.sv
// Multi-bit two-flop synchronizer for quasi-static asynchronous inputs
// (keypad rows and similar slow switches). Bits are synchronized
// independently; the consumer is expected to debounce, so per-bit skew on a
// transition is harmless.
module keypad_sync #(
  parameter int                WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner and debouncer. Rotates one active-low column,
// samples the synchronized rows, freezes on a single pressed key, debounces
// press and release, and emits one key_valid strobe per physical press with
// key_code = {column index, row index}.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_SCAN       | column driven for SCAN_DIV cycles, rows checked at the end
// ST_PRESS_DB   | column frozen, waiting for the latched row to stay stable
// ST_PRESSED    | key accepted, key_held high, waiting for all rows idle
// ST_RELEASE_DB | rows idle, waiting for the release to stay stable
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  keypad_scanner_if.master kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    row_s;

  state_e        state_q,     state_d;
  logic [1:0]    col_idx_q,   col_idx_d;
  logic [DW-1:0] dwell_q,     dwell_d;
  logic [BW-1:0] db_q,        db_d;
  logic [3:0]    row_lat_q,   row_lat_d;
  logic [3:0]    key_code_q,  key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q,  key_held_d;

  keypad_sync #(
    .WIDTH     (4),
    .RESET_VAL (ROW_IDLE)
  ) u_row_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (kp.row),
    .q_o     (row_s)
  );

  // State and datapath registers; reset wins over every other update.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= '0;
      dwell_q     <= '0;
      db_q        <= '0;
      row_lat_q   <= ROW_IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      row_lat_q   <= row_lat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state, counter and output logic for the scan/debounce sequence.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    dwell_d     = dwell_q;
    db_d        = db_q;
    row_lat_d   = row_lat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (single_low(row_s)) begin
            // Column stays put; the latched pattern is what must stay stable.
            row_lat_d = row_s;
            db_d      = '0;
            state_d   = ST_PRESS_DB;
          end else begin
            // Idle or multi-key ghosting pattern: move on to the next column.
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      ST_PRESS_DB: begin
        if (row_s != row_lat_q) begin
          // Bounce or glitch: rescan the same column from a fresh dwell.
          dwell_d = '0;
          state_d = ST_SCAN;
        end else if (db_q == DB_LAST) begin
          key_code_d  = {col_idx_q, low_index(row_lat_q)};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = ST_PRESSED;
        end else begin
          db_d = db_q + BW'(1);
        end
      end

      ST_PRESSED: begin
        // Extra keys in the held column are ignored until a full release.
        if (row_s == ROW_IDLE) begin
          db_d    = '0;
          state_d = ST_RELEASE_DB;
        end
      end

      ST_RELEASE_DB: begin
        if (row_s != ROW_IDLE) begin
          state_d = ST_PRESSED;
        end else if (db_q == DB_LAST) begin
          key_held_d = 1'b0;
          col_idx_d  = col_idx_q + 2'd1;
          dwell_d    = '0;
          state_d    = ST_SCAN;
        end else begin
          db_d = db_q + BW'(1);
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  assign kp.shift_col = col_drive(col_idx_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a behavioural 4x4 matrix: a pressed key pulls
// its row low only while its own column is driven. Directed scenarios cover
// idle rotation, press/release timing, bounce rejection, ghosting, reset
// mid-press and column wrap; a randomized phase checks one event per press.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  logic       key_down = 1'b0;
  logic [1:0] key_col  = 2'd0;
  logic [3:0] key_rows = 4'b1111;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_n),
    .kp      (kif)
  );

  always #5 clk = ~clk;

  // Matrix model: rows reflect the key only while its column is active-low.
  assign kif.row = (key_down && (kif.shift_col == ~(4'b0001 << key_col))) ? key_rows : 4'b1111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Record every strobe; a strobe must always coincide with key_held.
  always @(negedge clk) begin
    if (kif.key_valid === 1'b1) begin
      got_q.push_back(kif.key_code);
      chk("strobe_held", 32'(kif.key_held), 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic set_key(input logic [3:0] code);
    key_col  = code[3:2];
    key_rows = ~(4'b0001 << code[1:0]);
  endtask

  task automatic wait_valid(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      step(1);
      if (kif.key_valid === 1'b1) found = 1'b1;
    end
  endtask

  task automatic wait_held_fall(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      step(1);
      if (kif.key_held === 1'b0) found = 1'b1;
    end
  endtask

  bit         found;
  int         base;
  int         first_n;
  int         col_bad;
  bit         saw_col1;
  logic [3:0] exp_col;
  logic [3:0] code;

  initial begin
    // Reset values and idle rotation.
    reset_n = 1'b0;
    step(3);
    chk("rst_col", 32'(kif.shift_col), 32'h0000_000e);
    chk("rst_code", 32'(kif.key_code), 32'd0);
    chk("rst_valid", 32'(kif.key_valid), 32'd0);
    chk("rst_held", 32'(kif.key_held), 32'd0);
    reset_n = 1'b1;
    for (int n = 1; n <= 4 * SD; n++) begin
      step(1);
      exp_col = ~(4'b0001 << ((n / SD) % 4));
      chk("idle_rot", 32'(kif.shift_col), 32'(exp_col));
    end
    chk("idle_novalid", 32'(got_q.size()), 32'd0);

    // Key 0x6 held 100 cycles: one event, exact press latency, frozen column.
    do_reset();
    base = got_q.size();
    set_key(4'h6);
    key_down = 1'b1;
    first_n  = -1;
    col_bad  = 0;
    for (int n = 1; n <= 100; n++) begin
      step(1);
      if (kif.key_valid === 1'b1 && first_n < 0) first_n = n;
      if (first_n >= 0 && kif.shift_col !== 4'b1101) col_bad++;
    end
    chk("k6_latency", 32'(first_n), 32'(1 * SD + SD + DB));
    chk("k6_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) chk("k6_code", 32'(got_q[base]), 32'h6);
    chk("k6_col_frozen", 32'(col_bad), 32'd0);
    key_down = 1'b0;
    step(DB + 1);
    chk("k6_held_pre", 32'(kif.key_held), 32'd1);
    chk("k6_col_pre", 32'(kif.shift_col), 32'hd);
    step(2);
    chk("k6_held_post", 32'(kif.key_held), 32'd0);
    chk("k6_col_post", 32'(kif.shift_col), 32'hb);
    chk("k6_code_keep", 32'(kif.key_code), 32'h6);

    // Key 0x3 bouncing (low 5, high 3) is rejected; steady press accepted.
    do_reset();
    base = got_q.size();
    set_key(4'h3);
    for (int i = 0; i < 12; i++) begin
      key_down = 1'b1;
      step(5);
      key_down = 1'b0;
      step(3);
    end
    chk("k3_bounce", 32'(got_q.size() - base), 32'd0);
    key_down = 1'b1;
    wait_valid(60, found);
    chk("k3_found", 32'(found), 32'd1);
    chk("k3_code", 32'(kif.key_code), 32'h3);
    step(10);
    key_down = 1'b0;
    step(20);
    chk("k3_count", 32'(got_q.size() - base), 32'd1);

    // Two rows low in column 0: ignored, scanning continues.
    do_reset();
    base = got_q.size();
    key_col  = 2'd0;
    key_rows = 4'b1100;
    key_down = 1'b1;
    saw_col1 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      step(1);
      if (kif.shift_col === 4'b1101) saw_col1 = 1'b1;
      if (n == SD) chk("ghost_col", 32'(kif.shift_col), 32'hd);
    end
    chk("ghost_scan", 32'(saw_col1), 32'd1);
    chk("ghost_count", 32'(got_q.size() - base), 32'd0);
    key_down = 1'b0;

    // Key 0xA: reset during PRESSED drops held; released key gives no strobe.
    do_reset();
    base = got_q.size();
    set_key(4'hA);
    key_down = 1'b1;
    wait_valid(60, found);
    chk("kA_found", 32'(found), 32'd1);
    chk("kA_code", 32'(kif.key_code), 32'hA);
    step(5);
    reset_n  = 1'b0;
    key_down = 1'b0;
    step(1);
    chk("kA_rst_held", 32'(kif.key_held), 32'd0);
    chk("kA_rst_col", 32'(kif.shift_col), 32'he);
    chk("kA_rst_valid", 32'(kif.key_valid), 32'd0);
    reset_n = 1'b1;
    step(40);
    chk("kA_no_dup", 32'(got_q.size() - base), 32'd1);
    // Same again but the key stays down: re-debounced, exactly one new strobe.
    key_down = 1'b1;
    wait_valid(60, found);
    chk("kA2_found", 32'(found), 32'd1);
    step(3);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("kA2_rst_held", 32'(kif.key_held), 32'd0);
    step(60);
    chk("kA2_count", 32'(got_q.size() - base), 32'd3);
    if (got_q.size() == base + 3) chk("kA2_code", 32'(got_q[base + 2]), 32'hA);
    key_down = 1'b0;
    step(20);

    // Key 0xF in the last column; after release the scan wraps to column 0.
    do_reset();
    base = got_q.size();
    set_key(4'hF);
    key_down = 1'b1;
    wait_valid(60, found);
    chk("kF_found", 32'(found), 32'd1);
    chk("kF_code", 32'(kif.key_code), 32'hF);
    step(10);
    key_down = 1'b0;
    wait_held_fall(30, found);
    chk("kF_release", 32'(found), 32'd1);
    chk("kF_wrap", 32'(kif.shift_col), 32'he);
    chk("kF_count", 32'(got_q.size() - base), 32'd1);

    // Randomized presses, some preceded by short glitches on the same key.
    do_reset();
    base = got_q.size();
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      code = 4'($urandom_range(0, 15));
      set_key(code);
      if ($urandom_range(0, 1) == 1) begin
        key_down = 1'b1;
        step($urandom_range(1, DB));
        key_down = 1'b0;
        step($urandom_range(3, 6));
      end
      key_down = 1'b1;
      step($urandom_range(40, 80));
      exp_q.push_back(code);
      key_down = 1'b0;
      step($urandom_range(16, 30));
    end
    chk("rnd_count", 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) chk("rnd_code", 32'(got_q[base + i]), 32'(exp_q[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
